matrix_mult_seq: RTL
====================

MATRIX_MULT_SEQ -- requirements
Module: matrix_mult_seq

Interface
REQ-001 The block SHALL have parameter N, default 10, matrix dimension, legal range 2..16.
REQ-002 The block SHALL have parameter DW, default 8, unsigned element width in bits, legal range 2..16.
REQ-003 The block SHALL have port clk  input  1  the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port start  input  1  request to multiply the current A and B.
REQ-006 The block SHALL have port A  input  N*N*DW  flattened matrix A, element (r,c) at bits [(r*N+c)*DW +: DW].
REQ-007 The block SHALL have port B  input  N*N*DW  flattened matrix B, same packing as A.
REQ-008 The block SHALL have port C  output  N*N*DW  flattened result C = A x B, same packing as A.
REQ-009 The block SHALL have port busy  output  1  high while a multiplication is in progress.
REQ-010 The block SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-011 The block SHALL implement FSM states IDLE and CALC, plus an internal one-cycle done pulse.
REQ-012 In IDLE, start=1 at a rising edge SHALL capture A and B into internal operand registers, clear the accumulator, set i=j=k=0, enter CALC and assert busy from that edge.
REQ-013 Operands SHALL be sampled only at the accepting edge; A/B changes during CALC SHALL NOT affect the result.
REQ-014 In CALC, each edge SHALL perform exactly one MAC: acc <= acc + a[i][k]*b[k][j], unsigned, with acc at least 2*DW+clog2(N) bits wide so it never wraps.
REQ-015 When k=N-1, the element result SHALL be written to an internal result buffer at (i,j), acc cleared, k reset to 0, and j, then i, advanced in row-major order.
REQ-016 Element reduction to DW bits SHALL follow REQ-030/REQ-031.
REQ-017 The MAC for the final element (i=j=k=N-1) SHALL occur at the N^3-th edge after acceptance.
REQ-018 At that same N^3-th edge, the result buffer, including the final element, SHALL be copied to C, done set to 1, busy cleared, and the FSM returned to IDLE.
REQ-019 done SHALL be high for exactly one cycle; the latency from the accepting edge to done high SHALL be exactly N^3 cycles.
REQ-020 C SHALL change only at the done edge and at reset, and SHALL hold its value between those events.
REQ-021 start while busy=1 SHALL be ignored, with no queuing and no restart.
REQ-022 start=1 in the cycle where done=1, with the FSM already in IDLE, SHALL be accepted, giving back-to-back operation.
REQ-023 start held high continuously SHALL produce back-to-back multiplications, each completing with its own done pulse.

Reset
REQ-024 rst_n=0 SHALL immediately, without waiting for clk, force C=0, done=0, busy=0, FSM=IDLE and counters, accumulator and buffers to 0.
REQ-025 Reset asserted during CALC SHALL abort the operation: no done pulse, and C stays 0.
REQ-026 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which rst_n=1 and start=1.

Configuration
REQ-027 Macro MATRIX_MULT_SEQ_SAT_EN SHALL select the element reduction mode.
REQ-028 The port list and latency SHALL be identical with and without MATRIX_MULT_SEQ_SAT_EN.
REQ-029 The reduction mode SHALL be the only difference between the two builds.
REQ-030 With MATRIX_MULT_SEQ_SAT_EN undefined, each element SHALL be the low DW bits of the full sum (modulo 2^DW).
REQ-031 With MATRIX_MULT_SEQ_SAT_EN defined, each element SHALL be min(sum, 2^DW-1).

Verification
REQ-032 N=10, DW=8: A=identity, B all elements 3, start pulse -> done exactly 1000 cycles later, all C=3, busy low after done.
REQ-033 N=10, DW=8: A and B all 1 -> every C element = 10 (0x0A) in both builds.
REQ-034 N=10, DW=8: A and B all 16, sum 2560 -> without SAT_EN every C=0x00; with SAT_EN every C=0xFF.
REQ-035 N=2, DW=4: A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> done 8 cycles after acceptance; without SAT_EN C=[[3,6],[11,2]]; with SAT_EN C=[[15,15],[15,15]].
REQ-036 N=10: change A and pulse start at cycle 500 of a run -> both ignored, result matches the originally captured operands; start during the done cycle -> accepted, second done 1000 cycles later.
REQ-037 N=10: rst_n low asynchronously at cycle 300 -> busy, done and C read 0 immediately, no done pulse; then a fresh start with A and B all 1 -> all C=10.

Source files
------------

// File: rtl/matrix_mult_seq.sv
// Sequential NxN unsigned matrix multiplier: one MAC per clock, N^3 cycles per product.
// Define MATRIX_MULT_SEQ_SAT_EN to saturate each element to 2^DW-1 instead of wrapping modulo 2^DW.
module matrix_mult_seq #(
  parameter int N  = 10,
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N*N*DW-1:0] A,
  input  logic [N*N*DW-1:0] B,
  output logic [N*N*DW-1:0] C,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(N);
  localparam int EW = $clog2(N*N);
  localparam int AW = 2*DW + $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N-1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [DW-1:0] a_q [N*N];
  logic [DW-1:0] a_d [N*N];
  logic [DW-1:0] b_q [N*N];
  logic [DW-1:0] b_d [N*N];
  logic [DW-1:0] res_q [N*N];
  logic [DW-1:0] res_d [N*N];
  logic [N*N*DW-1:0] c_q, c_d;
  logic          done_q, done_d;

  logic [DW-1:0] a_in [N*N];
  logic [DW-1:0] b_in [N*N];
  logic [EW-1:0] a_idx, b_idx, r_idx;
  logic [AW-1:0] sum;
  logic [DW-1:0] elem;

  genvar gi;
  generate
    for (gi = 0; gi < N*N; gi++) begin : g_unpack
      assign a_in[gi] = A[gi*DW +: DW];
      assign b_in[gi] = B[gi*DW +: DW];
    end
  endgenerate

  assign a_idx = EW'(i_q) * EW'(N) + EW'(k_q);
  assign b_idx = EW'(k_q) * EW'(N) + EW'(j_q);
  assign r_idx = EW'(i_q) * EW'(N) + EW'(j_q);
  assign sum   = acc_q + AW'(a_q[a_idx]) * AW'(b_q[b_idx]);

`ifdef MATRIX_MULT_SEQ_SAT_EN
  localparam logic [AW-1:0] EL_MAX = {{(AW-DW){1'b0}}, {DW{1'b1}}};
  assign elem = (sum > EL_MAX) ? {DW{1'b1}} : sum[DW-1:0];
`else
  assign elem = sum[DW-1:0];
`endif

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    c_d     = c_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          a_d     = a_in;
          b_d     = b_in;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      CALC: begin
        if (k_q == LAST) begin
          // The last product of an element goes straight into the buffer, never through acc.
          res_d[r_idx] = elem;
          acc_d        = '0;
          k_d          = '0;
          if (j_q == LAST) begin
            j_d = '0;
            if (i_q == LAST) begin
              i_d     = '0;
              state_d = IDLE;
              done_d  = 1'b1;
              for (int n = 0; n < N*N; n++) begin
                c_d[n*DW +: DW] = res_d[n];
              end
            end else begin
              i_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          acc_d = sum;
          k_d   = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      res_q   <= '{default: '0};
      c_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

  assign C    = c_q;
  assign busy = (state_q == CALC);
  assign done = done_q;

endmodule
